// File: rtl/nios_oci_dct_pkg.sv
// Shared types and constants for the OCI debug-compressed-trace write side.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_oci_dct_pkg;

  localparam int SYM_W     = 2;
  localparam int BUF_SYMS  = 15;
  localparam int DCT_BUF_W = SYM_W * BUF_SYMS;
  localparam int DCT_CNT_W = 4;
  localparam int TW_W      = 36;

  localparam logic [1:0]           WORD_TAG = 2'b10;
  localparam logic [DCT_CNT_W-1:0] CNT_FULL = DCT_CNT_W'(BUF_SYMS);

  // Trace word as written to onchip trace memory, MSB first.
  typedef struct packed {
    logic [1:0]           tag;
    logic [DCT_CNT_W-1:0] count;
    logic [DCT_BUF_W-1:0] buffer;
  } tw_word_t;

endpackage

// File: rtl/nios_oci_dct_outreg.sv
// Single-entry valid/ready output register for packed trace words.
// Latency: word is valid the cycle after load.
// Backpressure: holds word stable while tw_ready is low; free = empty or draining.
module nios_oci_dct_outreg
  import nios_oci_dct_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  tw_word_t        load_word,
  output logic            free,
  output logic            tw_valid,
  output logic [TW_W-1:0] tw_data,
  input  logic            tw_ready
);

  tw_word_t word_q;

  // A load may land in the same cycle the previous word drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tw_valid <= 1'b0;
      word_q   <= '0;
    end else if (load) begin
      tw_valid <= 1'b1;
      word_q   <= load_word;
    end else if (tw_ready) begin
      tw_valid <= 1'b0;
    end
  end

  assign free    = !tw_valid || tw_ready;
  assign tw_data = word_q;

endmodule

// File: rtl/nios_oci_dct_packer.sv
// Packs 2-bit trace symbols into a 30-bit DCT buffer and emits 36-bit trace words.
// Latency: word valid one cycle after handoff (full buffer or flush); one symbol/cycle sustained.
// Backpressure: sym_ready drops only when buffer full and output blocked; with
// NIOS_OCI_DCT_DROP_EN defined the source is never stalled and such symbols are counted as dropped.
module nios_oci_dct_packer
  import nios_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_valid,
  input  logic [SYM_W-1:0]     sym_data,
  output logic                 sym_ready,
  input  logic                 flush,
  output logic                 tw_valid,
  output logic [TW_W-1:0]      tw_data,
  input  logic                 tw_ready,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic [15:0]          drop_count
);

  logic [DCT_BUF_W-1:0] buf_q, buf_nxt, buf_base;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_nxt, cnt_base;
  logic                 flush_pend_q, flush_pend_nxt;
  logic                 out_free, full, flush_req, handoff, can_take, accept;
  tw_word_t             load_word;

  assign full      = (cnt_q == CNT_FULL);
  // A pending flush is kept alive until the output register can take the word.
  assign flush_req = (flush || flush_pend_q) && (cnt_q != '0);
  assign handoff   = out_free && (full || flush_req);
  assign can_take  = !full || out_free;
  assign accept    = sym_valid && can_take;

`ifdef NIOS_OCI_DCT_DROP_EN
  logic [15:0] drop_q;
  logic        drop;

  assign sym_ready = 1'b1;
  assign drop      = sym_valid && !can_take;

  // Saturating count of symbols lost while full and blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign sym_ready  = can_take;
  assign drop_count = '0;
`endif

  // Next buffer: clear on handoff, then drop an accepted symbol into the next free slot.
  always_comb begin
    buf_base = handoff ? '0 : buf_q;
    cnt_base = handoff ? '0 : cnt_q;
    buf_nxt  = buf_base;
    if (accept) begin
      buf_nxt[SYM_W*int'(cnt_base) +: SYM_W] = sym_data;
    end
    cnt_nxt = cnt_base + DCT_CNT_W'(accept);

    flush_pend_nxt = flush_pend_q;
    if (handoff) begin
      flush_pend_nxt = 1'b0;
    end else if (flush && (cnt_q != '0)) begin
      flush_pend_nxt = 1'b1;
    end
  end

  // Packing state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      buf_q        <= buf_nxt;
      cnt_q        <= cnt_nxt;
      flush_pend_q <= flush_pend_nxt;
    end
  end

  // Word captured from the buffer as it stands at handoff.
  always_comb begin
    load_word        = '0;
    load_word.tag    = WORD_TAG;
    load_word.count  = cnt_q;
    load_word.buffer = buf_q;
  end

  nios_oci_dct_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (handoff),
    .load_word (load_word),
    .free      (out_free),
    .tw_valid  (tw_valid),
    .tw_data   (tw_data),
    .tw_ready  (tw_ready)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;

endmodule

// File: tb/tb_nios_oci_dct_packer.sv
// Directed bench for nios_oci_dct_packer.
// Inputs change on the falling edge; outputs sampled in the low phase.
// Emitted words are collected by a handshake monitor into a queue.
module tb_nios_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_data = 2'b00;
  logic        flush = 1'b0;
  logic        tw_ready = 1'b0;
  logic        sym_ready;
  logic        tw_valid;
  logic [35:0] tw_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [15:0] drop_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [35:0] words[$];

  nios_oci_dct_packer dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_ready  (sym_ready),
    .flush      (flush),
    .tw_valid   (tw_valid),
    .tw_data    (tw_data),
    .tw_ready   (tw_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Record every word that will be handed over on the coming rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset && tw_valid && tw_ready) words.push_back(tw_data);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Trace word layout: {tag 2'b10, count, buffer}.
  function automatic logic [35:0] mk(input logic [3:0] c, input logic [29:0] b);
    return {2'b10, c, b};
  endfunction

  task automatic push(input logic [1:0] s, output logic rdy);
    @(negedge clk);
    sym_valid = 1'b1;
    sym_data  = s;
    #1;
    rdy = sym_ready;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    sym_valid = 1'b0;
    flush     = 1'b0;
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    sym_valid = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (dct_buffer !== 30'h0) begin n_fail++; $display("FAIL reset_buffer: got %h required %h", dct_buffer, 30'h0); end
    n_checks++; if (dct_count !== 4'h0) begin n_fail++; $display("FAIL reset_count: got %h required %h", dct_count, 4'h0); end
    n_checks++; if (tw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tw_valid: got %b required 0", tw_valid); end
    n_checks++; if (tw_data !== 36'h0) begin n_fail++; $display("FAIL reset_tw_data: got %h required %h", tw_data, 36'h0); end
    n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop: got %h required 0", drop_count); end
    n_checks++; if (sym_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sym_ready: got %b required 1", sym_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_word();
    logic r;
    int   bad;
    words.delete();
    @(negedge clk);
    tw_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      push(2'b01, r);
      if (r !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_ready: got %0d stalls required 0", bad); end
    idle(3);
    n_checks++; if (words.size() != 1) begin n_fail++; $display("FAIL full_nwords: got %0d required 1", words.size()); end
    n_checks++; if (words.size() > 0 && words[0] !== mk(4'd15, 30'h15555555)) begin n_fail++; $display("FAIL full_word: got %h required %h", words[0], mk(4'd15, 30'h15555555)); end
    n_checks++; if (dct_count !== 4'h0) begin n_fail++; $display("FAIL full_count_clear: got %h required 0", dct_count); end
    n_checks++; if (dct_buffer !== 30'h0) begin n_fail++; $display("FAIL full_buffer_clear: got %h required 0", dct_buffer); end
  endtask

  task automatic test_flush();
    logic r;
    words.delete();
    push(2'b11, r);
    push(2'b00, r);
    push(2'b10, r);
    @(negedge clk);
    sym_valid = 1'b0;
    #1;
    n_checks++; if (dct_buffer !== 30'h023) begin n_fail++; $display("FAIL flush_live_buffer: got %h required %h", dct_buffer, 30'h023); end
    n_checks++; if (dct_count !== 4'd3) begin n_fail++; $display("FAIL flush_live_count: got %0d required 3", dct_count); end
    pulse_flush();
    idle(3);
    n_checks++; if (words.size() != 1) begin n_fail++; $display("FAIL flush_nwords: got %0d required 1", words.size()); end
    n_checks++; if (words.size() > 0 && words[0] !== mk(4'd3, 30'h023)) begin n_fail++; $display("FAIL flush_word: got %h required %h", words[0], mk(4'd3, 30'h023)); end
    pulse_flush();
    idle(3);
    n_checks++; if (words.size() != 1) begin n_fail++; $display("FAIL flush_empty: got %0d words required 1", words.size()); end
  endtask

  task automatic test_backpressure();
    logic        r;
    int          bad;
    logic [35:0] hold;
    words.delete();
    @(negedge clk);
    tw_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      push((i < 15) ? 2'b10 : 2'b11, r);
      if (r !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_ready: got %0d stalls required 0", bad); end
    push(2'b01, r);
    n_checks++; if (r !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got sym_ready %b required 0", r); end
    @(negedge clk);
    sym_valid = 1'b0;
    #1;
    hold = tw_data;
    n_checks++; if (hold !== mk(4'd15, 30'h2AAAAAAA)) begin n_fail++; $display("FAIL bp_first_word: got %h required %h", hold, mk(4'd15, 30'h2AAAAAAA)); end
    n_checks++; if (dct_buffer !== 30'h3FFFFFFF) begin n_fail++; $display("FAIL bp_second_buffer: got %h required %h", dct_buffer, 30'h3FFFFFFF); end
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (tw_valid !== 1'b1 || tw_data !== hold) begin n_fail++; $display("FAIL bp_hold: got %b/%h required 1/%h", tw_valid, tw_data, hold); end
    n_checks++; if (sym_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b required 0", sym_ready); end
    @(negedge clk);
    tw_ready = 1'b1;
    idle(4);
    n_checks++; if (words.size() != 2) begin n_fail++; $display("FAIL bp_nwords: got %0d required 2", words.size()); end
    n_checks++; if (words.size() > 1 && (words[0] !== mk(4'd15, 30'h2AAAAAAA) || words[1] !== mk(4'd15, 30'h3FFFFFFF))) begin n_fail++; $display("FAIL bp_order: got %h %h required %h %h", words[0], words[1], mk(4'd15, 30'h2AAAAAAA), mk(4'd15, 30'h3FFFFFFF)); end
    n_checks++; if (sym_ready !== 1'b1 || dct_count !== 4'h0) begin n_fail++; $display("FAIL bp_recover: got ready %b count %0d required 1 0", sym_ready, dct_count); end
    n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL bp_no_drop: got %0d required 0", drop_count); end
  endtask

  task automatic test_back_to_back();
    logic r;
    words.delete();
    @(negedge clk);
    tw_ready = 1'b1;
    for (int i = 0; i < 15; i++) push(2'b01, r);
    push(2'b10, r);
    n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b required 1", r); end
    @(negedge clk);
    sym_valid = 1'b0;
    #1;
    n_checks++; if (dct_count !== 4'd1 || dct_buffer !== 30'h2) begin n_fail++; $display("FAIL b2b_carry: got %0d/%h required 1/%h", dct_count, dct_buffer, 30'h2); end
    idle(3);
    n_checks++; if (words.size() != 1 || words[0] !== mk(4'd15, 30'h15555555)) begin n_fail++; $display("FAIL b2b_word: got %0d words first %h required 1 %h", words.size(), words[0], mk(4'd15, 30'h15555555)); end
    pulse_flush();
    idle(3);
    n_checks++; if (words.size() != 2 || words[1] !== mk(4'd1, 30'h2)) begin n_fail++; $display("FAIL b2b_next_word: got %0d words last %h required 2 %h", words.size(), words[words.size()-1], mk(4'd1, 30'h2)); end
  endtask

  task automatic test_flush_blocked();
    logic r;
    words.delete();
    @(negedge clk);
    tw_ready = 1'b0;
    for (int i = 0; i < 15; i++) push(2'b00, r);
    for (int i = 0; i < 4; i++) push(2'b01, r);
    pulse_flush();
    push(2'b11, r);
    push(2'b11, r);
    @(negedge clk);
    sym_valid = 1'b0;
    #1;
    n_checks++; if (dct_count !== 4'd6 || tw_valid !== 1'b1) begin n_fail++; $display("FAIL fb_pending: got count %0d valid %b required 6 1", dct_count, tw_valid); end
    @(negedge clk);
    tw_ready = 1'b1;
    idle(5);
    n_checks++; if (words.size() != 2) begin n_fail++; $display("FAIL fb_nwords: got %0d required 2", words.size()); end
    n_checks++; if (words.size() > 1 && (words[0] !== mk(4'd15, 30'h0) || words[1] !== mk(4'd6, 30'hF55))) begin n_fail++; $display("FAIL fb_words: got %h %h required %h %h", words[0], words[1], mk(4'd15, 30'h0), mk(4'd6, 30'hF55)); end
    n_checks++; if (dct_count !== 4'h0) begin n_fail++; $display("FAIL fb_count_clear: got %0d required 0", dct_count); end
  endtask

  task automatic test_drop();
    logic r;
    int   bad;
    words.delete();
    @(negedge clk);
    tw_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      push(2'b01, r);
      if (r !== 1'b1) bad++;
    end
    idle(1);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drop_ready: got %0d stalls required 0", bad); end
    n_checks++; if (drop_count !== 16'd10) begin n_fail++; $display("FAIL drop_count: got %0d required 10", drop_count); end
    @(negedge clk);
    tw_ready = 1'b1;
    idle(5);
    n_checks++; if (words.size() != 2) begin n_fail++; $display("FAIL drop_nwords: got %0d required 2", words.size()); end
    n_checks++; if (drop_count !== 16'd10) begin n_fail++; $display("FAIL drop_hold: got %0d required 10", drop_count); end
  endtask

  task automatic test_reset_mid();
    logic r;
    words.delete();
    @(negedge clk);
    tw_ready = 1'b0;
    for (int i = 0; i < 20; i++) push(2'b11, r);
    @(negedge clk);
    sym_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (dct_buffer !== 30'h0 || dct_count !== 4'h0) begin n_fail++; $display("FAIL mid_reset_buf: got %h/%0d required 0/0", dct_buffer, dct_count); end
    n_checks++; if (tw_valid !== 1'b0 || tw_data !== 36'h0) begin n_fail++; $display("FAIL mid_reset_out: got %b/%h required 0/0", tw_valid, tw_data); end
    n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL mid_reset_drop: got %0d required 0", drop_count); end
    @(negedge clk);
    reset = 1'b0;
    tw_ready = 1'b1;
    idle(4);
    n_checks++; if (words.size() != 0) begin n_fail++; $display("FAIL mid_reset_nowords: got %0d required 0", words.size()); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
`ifdef NIOS_OCI_DCT_DROP_EN
    test_drop();
`else
    test_backpressure();
`endif
    test_back_to_back();
    test_flush_blocked();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
